// File: rtl/led_chaser_pkg.sv
// Shared types and helpers for the led_chaser pattern generator.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    CHASE  = 2'b00,
    FILL   = 2'b01,
    BOUNCE = 2'b10,
    RSVD   = 2'b11
  } mode_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Widest pattern start_pattern can describe; callers size-cast down to NLEDS.
  localparam int unsigned MAX_LEDS = 64;

  function automatic logic [MAX_LEDS-1:0] start_pattern(mode_t mode, logic dir,
                                                        int unsigned nleds);
    logic [MAX_LEDS-1:0] pat;
    if (mode == FILL) begin
      pat = '0;
    end else if (dir == DIR_LEFT) begin
      pat = MAX_LEDS'(1);
    end else begin
      pat = MAX_LEDS'(1) << (nleds - 1);
    end
    return pat;
  endfunction

endpackage

// File: rtl/chaser_tick_gen.sv
// Step prescaler: counts 0..DIV-1 and fires tick on the terminal count.
module chaser_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  assign at_max = (cnt_q == CntMax);
  assign tick   = at_max && !clr && !hold;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (at_max) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// Parametrised LED chase / fill-bar / bounce generator with step and wrap pulses.
// BOUNCE mode is built only when LED_CHASER_BOUNCE_EN is defined.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int unsigned NLEDS = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             freeze,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [NLEDS-1:0] leds,
  output logic             step_pulse,
  output logic             wrap
);

  localparam logic [NLEDS-1:0] LsbOne = NLEDS'(1);
  localparam logic [NLEDS-1:0] MsbOne = LsbOne << (NLEDS - 1);
  localparam logic [NLEDS-1:0] AllOne = '1;

  logic [NLEDS-1:0] leds_q, leds_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  mode_t            mode_q, mode_d;
  logic             dir_q, dir_d;
`ifdef LED_CHASER_BOUNCE_EN
  localparam logic [NLEDS-1:0] LsbNb = NLEDS'(2);
  localparam logic [NLEDS-1:0] MsbNb = MsbOne >> 1;
  logic             bdir_q, bdir_d;
`endif

  mode_t            mode_eff;
  logic [NLEDS-1:0] start_pat;
  logic             load;
  logic             tick;

  always_comb begin
    case (mode)
      2'b01:   mode_eff = FILL;
`ifdef LED_CHASER_BOUNCE_EN
      2'b10:   mode_eff = BOUNCE;
`endif
      default: mode_eff = CHASE;
    endcase
  end

  assign start_pat = NLEDS'(start_pattern(mode_eff, dir, NLEDS));

  // A FILL direction flip restarts the bar, but only when not frozen.
  assign load = clear || (mode_eff != mode_q) ||
                (!freeze && (mode_q == FILL) && (dir != dir_q));

  chaser_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk_2),
    .rst_n(reset_n),
    .clr  (load),
    .hold (freeze),
    .tick (tick)
  );

  always_comb begin
    leds_d = leds_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    mode_d = mode_q;
    dir_d  = dir_q;
`ifdef LED_CHASER_BOUNCE_EN
    bdir_d = bdir_q;
`endif
    if (load) begin
      leds_d = start_pat;
      mode_d = mode_eff;
      dir_d  = dir;
`ifdef LED_CHASER_BOUNCE_EN
      bdir_d = dir;
`endif
    end else if (!freeze) begin
      dir_d = dir;
      if (tick) begin
        step_d = 1'b1;
        case (mode_q)
          FILL: begin
            if (leds_q == AllOne) begin
              leds_d = '0;
              wrap_d = 1'b1;
            end else if (dir == DIR_RIGHT) begin
              leds_d = (leds_q >> 1) | MsbOne;
            end else begin
              leds_d = (leds_q << 1) | LsbOne;
            end
          end
`ifdef LED_CHASER_BOUNCE_EN
          BOUNCE: begin
            if (bdir_q == DIR_RIGHT) begin
              if (leds_q[0]) begin
                leds_d = LsbNb;
                bdir_d = DIR_LEFT;
                wrap_d = 1'b1;
              end else begin
                leds_d = leds_q >> 1;
              end
            end else begin
              if (leds_q[NLEDS-1]) begin
                leds_d = MsbNb;
                bdir_d = DIR_RIGHT;
                wrap_d = 1'b1;
              end else begin
                leds_d = leds_q << 1;
              end
            end
          end
`endif
          default: begin
            if (dir == DIR_RIGHT) begin
              if (leds_q[0]) begin
                leds_d = MsbOne;
                wrap_d = 1'b1;
              end else begin
                leds_d = leds_q >> 1;
              end
            end else begin
              if (leds_q[NLEDS-1]) begin
                leds_d = LsbOne;
                wrap_d = 1'b1;
              end else begin
                leds_d = leds_q << 1;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      leds_q <= MsbOne;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      mode_q <= CHASE;
      dir_q  <= DIR_RIGHT;
`ifdef LED_CHASER_BOUNCE_EN
      bdir_q <= DIR_RIGHT;
`endif
    end else begin
      leds_q <= leds_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
`ifdef LED_CHASER_BOUNCE_EN
      bdir_q <= bdir_d;
`endif
    end
  end

  assign leds       = leds_q;
  assign step_pulse = step_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser: NLEDS=4 at DIV=1 and DIV=3.
module tb_led_chaser;

  localparam int unsigned N = 4;

  logic clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic         reset_n;
  logic         clear1, freeze1, dir1;
  logic [1:0]   mode1;
  logic [N-1:0] leds1;
  logic         sp1, wr1;
  logic         clear3, freeze3, dir3;
  logic [1:0]   mode3;
  logic [N-1:0] leds3;
  logic         sp3, wr3;

  led_chaser #(.NLEDS(N), .DIV(1)) u_dut1 (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .clear     (clear1),
    .freeze    (freeze1),
    .dir       (dir1),
    .mode      (mode1),
    .leds      (leds1),
    .step_pulse(sp1),
    .wrap      (wr1)
  );

  led_chaser #(.NLEDS(N), .DIV(3)) u_dut3 (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .clear     (clear3),
    .freeze    (freeze3),
    .dir       (dir3),
    .mode      (mode3),
    .leds      (leds3),
    .step_pulse(sp3),
    .wrap      (wr3)
  );

  typedef struct {
    logic       clr;
    logic       frz;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] leds;
    logic       sp;
    logic       wr;
  } vec_t;

  typedef struct {
    int unsigned dut;
    logic [3:0]  leds;
    logic        sp;
    logic        wr;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t t1[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t v(logic clr, logic frz, logic dir, logic [1:0] mode,
                             logic [3:0] leds, logic sp, logic wr);
    vec_t r;
    r.clr = clr; r.frz = frz; r.dir = dir; r.mode = mode;
    r.leds = leds; r.sp = sp; r.wr = wr;
    return r;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    if (e.dut == 1) begin
      check({e.name, " leds"}, {4'b0, leds1}, {4'b0, e.leds});
      check({e.name, " step"}, {7'b0, sp1}, {7'b0, e.sp});
      check({e.name, " wrap"}, {7'b0, wr1}, {7'b0, e.wr});
    end else begin
      check({e.name, " leds"}, {4'b0, leds3}, {4'b0, e.leds});
      check({e.name, " step"}, {7'b0, sp3}, {7'b0, e.sp});
      check({e.name, " wrap"}, {7'b0, wr3}, {7'b0, e.wr});
    end
  endtask

  // Drive one clock of stimulus, queue its expectation, sample #1 after the edge.
  task automatic run_vec(int unsigned dut, vec_t x, string name);
    exp_t e;
    if (dut == 1) begin
      clear1 = x.clr; freeze1 = x.frz; dir1 = x.dir; mode1 = x.mode;
    end else begin
      clear3 = x.clr; freeze3 = x.frz; dir3 = x.dir; mode3 = x.mode;
    end
    e.dut = dut; e.leds = x.leds; e.sp = x.sp; e.wr = x.wr; e.name = name;
    sb.push_back(e);
    @(posedge clk_2);
    #1;
    pop_check();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_2);
    #1;
    check("reset leds1", {4'b0, leds1}, 8'b0000_1000);
    check("reset pulses1", {6'b0, sp1, wr1}, 8'b0);
    check("reset leds3", {4'b0, leds3}, 8'b0000_1000);
    check("reset pulses3", {6'b0, sp3, wr3}, 8'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat3[4];
    logic [3:0] prev;

    // Main DIV=1 table, applied after a clean reset.
    t1.push_back(v(0,0,0,2'd0,4'b0100,1,0));
    t1.push_back(v(0,0,0,2'd0,4'b0010,1,0));
    t1.push_back(v(0,0,0,2'd0,4'b0001,1,0));
    t1.push_back(v(0,0,0,2'd0,4'b1000,1,1));
    t1.push_back(v(0,0,0,2'd0,4'b0100,1,0));
    t1.push_back(v(0,0,0,2'd0,4'b0010,1,0));
    for (int i = 0; i < 5; i++) t1.push_back(v(0,1,0,2'd0,4'b0010,0,0));
    t1.push_back(v(0,0,0,2'd0,4'b0001,1,0));
    t1.push_back(v(1,1,0,2'd0,4'b1000,0,0));
    t1.push_back(v(0,0,0,2'd0,4'b0100,1,0));
    // FILL right, then direction flip reloads and fills from the LSB.
    t1.push_back(v(0,0,0,2'd1,4'b0000,0,0));
    t1.push_back(v(0,0,0,2'd1,4'b1000,1,0));
    t1.push_back(v(0,0,0,2'd1,4'b1100,1,0));
    t1.push_back(v(0,0,0,2'd1,4'b1110,1,0));
    t1.push_back(v(0,0,0,2'd1,4'b1111,1,0));
    t1.push_back(v(0,0,0,2'd1,4'b0000,1,1));
    t1.push_back(v(0,0,0,2'd1,4'b1000,1,0));
    t1.push_back(v(0,0,0,2'd1,4'b1100,1,0));
    t1.push_back(v(0,0,1,2'd1,4'b0000,0,0));
    t1.push_back(v(0,0,1,2'd1,4'b0001,1,0));
    t1.push_back(v(0,0,1,2'd1,4'b0011,1,0));
    t1.push_back(v(0,1,0,2'd1,4'b0011,0,0));
    t1.push_back(v(0,0,0,2'd1,4'b0000,0,0));
    // CHASE left start, then dir change continues from current position.
    t1.push_back(v(0,0,1,2'd0,4'b0001,0,0));
    t1.push_back(v(0,0,1,2'd0,4'b0010,1,0));
    t1.push_back(v(0,0,0,2'd0,4'b0001,1,0));
    t1.push_back(v(0,0,0,2'd0,4'b1000,1,1));
    t1.push_back(v(1,0,0,2'd0,4'b1000,0,0));
`ifdef LED_CHASER_BOUNCE_EN
    t1.push_back(v(0,0,0,2'd2,4'b1000,0,0));
    t1.push_back(v(0,0,0,2'd2,4'b0100,1,0));
    t1.push_back(v(0,0,0,2'd2,4'b0010,1,0));
    t1.push_back(v(0,0,0,2'd2,4'b0001,1,0));
    t1.push_back(v(0,0,0,2'd2,4'b0010,1,1));
    t1.push_back(v(0,0,1,2'd2,4'b0100,1,0));
    t1.push_back(v(0,0,1,2'd2,4'b1000,1,0));
    t1.push_back(v(0,0,1,2'd2,4'b0100,1,1));
    t1.push_back(v(0,0,0,2'd3,4'b1000,0,0));
    t1.push_back(v(0,0,0,2'd3,4'b0100,1,0));
`else
    t1.push_back(v(0,0,0,2'd2,4'b0100,1,0));
    t1.push_back(v(0,0,0,2'd2,4'b0010,1,0));
    t1.push_back(v(0,0,0,2'd2,4'b0001,1,0));
    t1.push_back(v(0,0,0,2'd2,4'b1000,1,1));
    t1.push_back(v(0,0,0,2'd2,4'b0100,1,0));
    t1.push_back(v(0,0,0,2'd2,4'b0010,1,0));
    t1.push_back(v(0,0,0,2'd2,4'b0001,1,0));
    t1.push_back(v(0,0,0,2'd2,4'b1000,1,1));
    t1.push_back(v(0,0,0,2'd3,4'b0100,1,0));
    t1.push_back(v(0,0,0,2'd3,4'b0010,1,0));
`endif
    t1.push_back(v(0,0,0,2'd1,4'b0000,0,0));
    t1.push_back(v(0,0,0,2'd1,4'b1000,1,0));
    t1.push_back(v(0,0,0,2'd1,4'b1100,1,0));
    t1.push_back(v(0,0,0,2'd1,4'b1110,1,0));

    clear1 = 0; freeze1 = 0; dir1 = 0; mode1 = 2'd0;
    clear3 = 0; freeze3 = 0; dir3 = 1; mode3 = 2'd0;

    // DIV=3: step every third clock, prescaler restart and hold.
    do_reset();
    pat3[0] = 4'b0010; pat3[1] = 4'b0100; pat3[2] = 4'b1000; pat3[3] = 4'b0001;
    run_vec(3, v(1,0,1,2'd0,4'b0001,0,0), "d3 clear");
    prev = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      run_vec(3, v(0,0,1,2'd0,prev,0,0), $sformatf("d3 idle%0da", k));
      run_vec(3, v(0,0,1,2'd0,prev,0,0), $sformatf("d3 idle%0db", k));
      run_vec(3, v(0,0,1,2'd0,pat3[k],1,(k == 3)), $sformatf("d3 step%0d", k));
      prev = pat3[k];
    end
    run_vec(3, v(0,0,1,2'd0,4'b0001,0,0), "d3 cnt1");
    run_vec(3, v(0,0,0,2'd1,4'b0000,0,0), "d3 modechg");
    run_vec(3, v(0,0,0,2'd1,4'b0000,0,0), "d3 fill c1");
    run_vec(3, v(0,0,0,2'd1,4'b0000,0,0), "d3 fill c2");
    run_vec(3, v(0,0,0,2'd1,4'b1000,1,0), "d3 fill step");
    run_vec(3, v(0,0,0,2'd1,4'b1000,0,0), "d3 pre cnt1");
    for (int k = 0; k < 3; k++) run_vec(3, v(0,1,0,2'd1,4'b1000,0,0), $sformatf("d3 frz%0d", k));
    run_vec(3, v(0,0,0,2'd1,4'b1000,0,0), "d3 post cnt2");
    run_vec(3, v(0,0,0,2'd1,4'b1100,1,0), "d3 post step");

    // DIV=1 table.
    clear3 = 0; freeze3 = 0; dir3 = 0; mode3 = 2'd0;
    do_reset();
    foreach (t1[i]) run_vec(1, t1[i], $sformatf("t1[%0d]", i));

    // Asynchronous reset between edges while frozen, mid-FILL at 1110.
    #2;
    freeze1 = 1'b1;
    reset_n = 1'b0;
    #1;
    check("async rst leds", {4'b0, leds1}, 8'b0000_1000);
    check("async rst pulses", {6'b0, sp1, wr1}, 8'b0);
    @(posedge clk_2);
    #1;
    check("rst held leds", {4'b0, leds1}, 8'b0000_1000);
    reset_n = 1'b1;
    run_vec(1, v(0,0,0,2'd0,4'b0100,1,0), "post rst step");
    run_vec(1, v(0,0,0,2'd1,4'b0000,0,0), "chase->fill");
    run_vec(1, v(0,0,0,2'd1,4'b1000,1,0), "fill first");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_chaser.md
Name: led_chaser

Overview:
Parametrised LED pattern generator, successor to the 8-bit pisca-pisca. Drives NLEDS outputs with chase, fill-bar or bounce patterns, advancing one step every DIV clocks. Supports freeze, synchronous clear and direction select. Emits step and wrap pulses for chaining or display logic. Sits in top between the switch decode and LED.

Parameters:
NLEDS, 8, number of LED outputs (>= 2)
DIV, 1, clocks per pattern step (>= 1; 1 = step every clock)

Ports:
clk_2  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
clear  input  1  synchronous restart of pattern and prescaler
freeze  input  1  hold pattern and prescaler
dir  input  1  0 = right (MSB->LSB), 1 = left (LSB->MSB)
mode  input  2  00 CHASE, 01 FILL, 10 BOUNCE, 11 reserved (= CHASE)
leds  output  NLEDS  current pattern
step_pulse  output  1  high for exactly the cycle in which leds shows a newly stepped value
wrap  output  1  high with step_pulse when the step is a pattern restart or bounce reversal

Behaviour:
- Reset (async assert, sync release): leds = 1<<(NLEDS-1), prescaler = 0, mode_q = CHASE, dir_q = 0, bounce direction = right, step_pulse = wrap = 0.
- Start pattern: CHASE/BOUNCE: dir=0 -> MSB only, dir=1 -> LSB only. FILL: all zeros.
- Prescaler: counts 0..DIV-1. A step fires on the edge where count == DIV-1; count returns to 0. Width is $clog2(DIV), minimum 1. For DIV=1 every clock is a step.
- Priority per clock: clear > mode change > freeze > step.
- clear: load start pattern for the current mode/dir. Prescaler = 0. No pulses.
- Mode change (mode != mode_q): same action as clear, then mode_q updates. Reserved mode 11 is mapped to CHASE before comparison.
- freeze: leds and prescaler hold. No pulses.
- CHASE step:
  - dir=0: leds>>1. If leds was LSB-only, load MSB-only and assert wrap.
  - dir=1: mirror image.
  - A dir change continues from the current position. No zero state is ever shown.
- FILL step:
  - dir=0: 0 -> MSB -> MSB|MSB-1 ... -> all ones -> 0 with wrap; dir=1 mirrored.
  - A dir change (dir != dir_q) reloads the start pattern, like clear.
- BOUNCE step:
  - A single bit moves in the internal direction. Leaving an end reverses: the bit moves to the neighbour position and wrap is asserted.
  - N=4 sequence: 1000,0100,0010,0001,0010 (wrap),0100,1000 (wrap on the following step).
  - dir is sampled only at load.
- step_pulse and wrap are registered and coincident with the leds update.
- The output pattern is never all-zeros except in FILL.
- Reset mid-operation always returns to the reset values regardless of freeze.

Optional Feature:
LED_CHASER_BOUNCE_EN.
- Defined: BOUNCE mode as above.
- Undefined: mode 10 is mapped to CHASE (like 11), the bounce-direction register is not built, and wrap for mode 10 follows CHASE rules.

Decomposition:
- Package led_chaser_pkg holds:
  - enum mode_t {CHASE, FILL, BOUNCE, RSVD} (2 bits)
  - constant DIR_RIGHT = 0, DIR_LEFT = 1
  - function start_pattern(mode, dir, nleds)
- Sub-module chaser_tick_gen(DIV): prescaler with inputs clr and hold, output tick.
- led_chaser contains the pattern register, mode_q/dir_q change detection and the step logic.

Test Plan:
1. NLEDS=4, DIV=1, CHASE, dir=0, release reset -> leds 1000,0100,0010,0001,1000. wrap high only with the final 1000. step_pulse high every cycle.
2. NLEDS=4, DIV=3, CHASE, dir=1 -> leds changes every 3rd clock: 0001,0010,0100,1000,0001. step_pulse is high 1 of every 3 cycles.
3. CHASE running at 0010. Assert freeze for 5 clocks -> leds stays 0010 with no pulses. Release -> next step 0001. Assert clear and freeze together -> leds 1000 (dir=0).
4. NLEDS=4, FILL, dir=0 -> 0000,1000,1100,1110,1111,0000 (wrap). Toggle dir at 1100 -> next clock 0000, then 0001,0011.
5. NLEDS=4, BOUNCE, dir=0 -> 1000,0100,0010,0001,0010 (wrap),0100,1000,0100 (wrap). With LED_CHASER_BOUNCE_EN undefined -> the CHASE sequence of test 1.
6. Pull reset_n low mid-FILL at 1110 between clock edges -> leds immediately 1000 and pulses 0. Mode change CHASE->FILL at 0100 -> next clock 0000, prescaler restarted.
